led_panel_receiver: RTL and testbench

Panel-side receiver for the 1-bit RGB HUB75 LED panel bus: it oversamples the six RGB lines, the 5-bit row address, BLANK, LATCH and SCLK, and deserializes one row of columns per LATCH pulse. It decodes FM6126 register writes by counting the SCLK edges that occur while LATCH is high. Captured rows go out through a valid/ready handshake, and protocol errors are flagged. It sits in loopback/bring-up builds and testbenches as the far end of the panel driver, fed either from the 16-bit panel bus or from external pins.

---
 rtl/led_panel_pkg.sv | 27 ++
 rtl/bus_synchronizer.sv | 41 ++++
 rtl/led_panel_receiver.sv | 236 +++++++++++++++++++++++
 tb/tb_led_panel_receiver.sv | 371 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/led_panel_pkg.sv
// -----------------------------------------------------------------------------
// led_panel_pkg
// Shared constants for the HUB75 panel receiver: FM6126 register-select latch
// lengths, FSM state encodings, default row width and counter limits.
// -----------------------------------------------------------------------------
package led_panel_pkg;

    // Columns per row when the top is instantiated without overrides
    localparam int DEFAULT_WIDTH = 64;

    // Panel lines carried through the synchronizer:
    // rgb0(3) + rgb1(3) + addr(5) + blank + latch + sclk
    localparam int PANEL_LINES = 14;

    // Number of SCLK edges seen while LATCH is high that select an FM6126 register
    localparam logic [4:0] FM_LATCH_REG1 = 5'd11;
    localparam logic [4:0] FM_LATCH_REG2 = 5'd12;

    // Capture state machine encodings
    localparam logic [0:0] S_SHIFT = 1'b0;
    localparam logic [0:0] S_LATCH = 1'b1;

    // Saturation limits of the column and latch-clock counters
    localparam logic [6:0] COL_CNT_MAX = 7'd127;
    localparam logic [4:0] LAT_CNT_MAX = 5'd31;

endpackage

// File: rtl/bus_synchronizer.sv
// -----------------------------------------------------------------------------
// bus_synchronizer
// Multi-flop synchronizer for a bundle of asynchronous lines. Every bit goes
// through DEPTH flops; all bits see identical latency so lines that change
// together at the source stay aligned at the output.
//
// Ports:
//   clk    - destination clock
//   resetn - asynchronous active-low reset, clears every stage to 0
//   d      - asynchronous input lines
//   q      - synchronized lines (DEPTH cycles of latency)
// -----------------------------------------------------------------------------
module bus_synchronizer #(
    parameter int WIDTH = 1,
    parameter int DEPTH = 2
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);

    logic [WIDTH-1:0] stages [DEPTH];

    // Plain shift chain; stage 0 is the metastability-catching flop
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            for (int i = 0; i < DEPTH; i++) begin
                stages[i] <= '0;
            end
        end else begin
            stages[0] <= d;
            for (int i = 1; i < DEPTH; i++) begin
                stages[i] <= stages[i-1];
            end
        end
    end

    assign q = stages[DEPTH-1];

endmodule

// File: rtl/led_panel_receiver.sv
// -----------------------------------------------------------------------------
// led_panel_receiver
// Far end of a HUB75 panel driver. Oversamples the panel bus, shifts RGB data
// on SCLK rising edges, and on each LATCH pulse either emits a captured row
// (no SCLK edges during LATCH) or records an FM6126 register write (11 or 12
// SCLK edges during LATCH). Anything else is flagged as a latch error.
//
// Ports:
//   clk, resetn              - capture clock, async active-low reset
//   panel_rgb0 / panel_rgb1  - upper / lower half R,G,B (bit 2 = red)
//   panel_addr               - row address
//   panel_blank/latch/sclk   - panel control lines (asynchronous)
//   row_valid / row_ready    - single-entry row output handshake
//   row_addr                 - address sampled at the LATCH falling edge
//   row_data0 / row_data1    - column x at bits [3x+2:3x]
//   row_cols                 - SCLK edges counted for the row (saturating)
//   fm_reg1 / fm_reg2        - last value written to each FM6126 register
//   fm_written               - sticky: bit0 REG1 written, bit1 REG2 written
//   err_overrun/cols/latch   - sticky protocol error flags
//   clear_errors             - pulse that clears the error flags
// -----------------------------------------------------------------------------
module led_panel_receiver
    import led_panel_pkg::*;
#(
    parameter int WIDTH       = DEFAULT_WIDTH,
    parameter int SYNC_STAGES = 2
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic [2:0]           panel_rgb0,
    input  logic [2:0]           panel_rgb1,
    input  logic [4:0]           panel_addr,
    input  logic                 panel_blank,
    input  logic                 panel_latch,
    input  logic                 panel_sclk,
    output logic                 row_valid,
    input  logic                 row_ready,
    output logic [4:0]           row_addr,
    output logic [3*WIDTH-1:0]   row_data0,
    output logic [3*WIDTH-1:0]   row_data1,
    output logic [6:0]           row_cols,
    output logic [15:0]          fm_reg1,
    output logic [15:0]          fm_reg2,
    output logic [1:0]           fm_written,
    output logic                 err_overrun,
    output logic                 err_cols,
    output logic                 err_latch,
    input  logic                 clear_errors
);

    localparam logic [6:0] WIDTH_COLS = 7'(WIDTH);

    logic [PANEL_LINES-1:0] bus_raw;
    logic [PANEL_LINES-1:0] bus_sync;

    logic [2:0] rgb0_s;
    logic [2:0] rgb1_s;
    logic [4:0] addr_s;
    logic       blank_s;
    logic       latch_s;
    logic       sclk_s;
    logic       latch_prev;
    logic       sclk_prev;

    logic       sclk_rise;
    logic       latch_rise;
    logic       latch_fall;
    logic       latch_done;

    logic [0:0]           state;
    logic [3*WIDTH-1:0]   sr0;
    logic [3*WIDTH-1:0]   sr1;
    logic [15:0]          reg_sr;
    logic [6:0]           col_cnt;
    logic [4:0]           lat_cnt;

    logic is_row;
    logic is_reg1;
    logic is_reg2;
    logic is_bad;
    logic slot_free;
    logic load_row;
    logic unused_blank;

    // All panel lines share one synchronizer so simultaneous source edges
    // (e.g. SCLK and LATCH) arrive in the same clk cycle
    assign bus_raw = {panel_rgb0, panel_rgb1, panel_addr,
                      panel_blank, panel_latch, panel_sclk};

    bus_synchronizer #(
        .WIDTH (PANEL_LINES),
        .DEPTH (SYNC_STAGES)
    ) u_sync (
        .clk    (clk),
        .resetn (resetn),
        .d      (bus_raw),
        .q      (bus_sync)
    );

    assign rgb0_s  = bus_sync[13:11];
    assign rgb1_s  = bus_sync[10:8];
    assign addr_s  = bus_sync[7:3];
    assign blank_s = bus_sync[2];
    assign latch_s = bus_sync[1];
    assign sclk_s  = bus_sync[0];

    // BLANK only gates LED drive on a real panel; it does not affect capture
    assign unused_blank = blank_s;

    // One extra register stage gives the previous level for edge detection
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            latch_prev <= 1'b0;
            sclk_prev  <= 1'b0;
        end else begin
            latch_prev <= latch_s;
            sclk_prev  <= sclk_s;
        end
    end

    assign sclk_rise  = sclk_s & ~sclk_prev;
    assign latch_rise = latch_s & ~latch_prev;
    assign latch_fall = ~latch_s & latch_prev;
    assign latch_done = (state == S_LATCH) && latch_fall;

    // Decode of the number of SCLK edges seen while LATCH was high
    assign is_row  = latch_done && (lat_cnt == 5'd0);
    assign is_reg1 = latch_done && (lat_cnt == FM_LATCH_REG1);
    assign is_reg2 = latch_done && (lat_cnt == FM_LATCH_REG2);
    assign is_bad  = latch_done && !is_row && !is_reg1 && !is_reg2;

    // The slot is free if empty or being drained this very cycle
    assign slot_free = !row_valid || row_ready;
    assign load_row  = is_row && slot_free;

    // Two-state FSM tracking whether LATCH is currently asserted
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state <= S_SHIFT;
        end else begin
            case (state)
                S_SHIFT: if (latch_rise) state <= S_LATCH;
                S_LATCH: if (latch_fall) state <= S_SHIFT;
                default: state <= S_SHIFT;
            endcase
        end
    end

    // Column data and the FM register shifter move on every SCLK rising edge;
    // the row output takes a snapshot, so these are never cleared by LATCH
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            sr0    <= '0;
            sr1    <= '0;
            reg_sr <= '0;
        end else if (sclk_rise) begin
            sr0    <= {rgb0_s, sr0[3*WIDTH-1:3]};
            sr1    <= {rgb1_s, sr1[3*WIDTH-1:3]};
            reg_sr <= {reg_sr[14:0], rgb0_s[2]};
        end
    end

    // Column counter; an SCLK edge coincident with the closing LATCH edge is
    // the first column of the next row
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            col_cnt <= '0;
        end else if (latch_done) begin
            col_cnt <= sclk_rise ? 7'd1 : 7'd0;
        end else if (sclk_rise && (col_cnt != COL_CNT_MAX)) begin
            col_cnt <= col_cnt + 7'd1;
        end
    end

    // Counts SCLK edges while LATCH is high; restarts on each LATCH rise
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            lat_cnt <= '0;
        end else if ((state == S_SHIFT) && latch_rise) begin
            lat_cnt <= sclk_rise ? 5'd1 : 5'd0;
        end else if (sclk_rise && latch_s && (lat_cnt != LAT_CNT_MAX)) begin
            lat_cnt <= lat_cnt + 5'd1;
        end
    end

    // Single-entry row output; a full slot drops the new row
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            row_valid <= 1'b0;
            row_addr  <= '0;
            row_data0 <= '0;
            row_data1 <= '0;
            row_cols  <= '0;
        end else if (load_row) begin
            row_valid <= 1'b1;
            row_addr  <= addr_s;
            row_data0 <= sr0;
            row_data1 <= sr1;
            row_cols  <= col_cnt;
        end else if (row_valid && row_ready) begin
            row_valid <= 1'b0;
        end
    end

    // FM6126 register capture from the serial shifter
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            fm_reg1    <= '0;
            fm_reg2    <= '0;
            fm_written <= '0;
        end else begin
            if (is_reg1) begin
                fm_reg1       <= reg_sr;
                fm_written[0] <= 1'b1;
            end
            if (is_reg2) begin
                fm_reg2       <= reg_sr;
                fm_written[1] <= 1'b1;
            end
        end
    end

    // Sticky error flags; a new error in the clearing cycle still sets the flag
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            err_overrun <= 1'b0;
            err_cols    <= 1'b0;
            err_latch   <= 1'b0;
        end else begin
            err_overrun <= (err_overrun & ~clear_errors) | (is_row & ~slot_free);
            err_cols    <= (err_cols & ~clear_errors) | (is_row & (col_cnt != WIDTH_COLS));
            err_latch   <= (err_latch & ~clear_errors) | is_bad;
        end
    end

endmodule

// File: tb/tb_led_panel_receiver.sv
// -----------------------------------------------------------------------------
// tb_led_panel_receiver
// Self-checking bench for led_panel_receiver. A reference model keeps the
// full history of shifted columns and derives each row as the last WIDTH
// columns, the FM shifter as the last 16 red bits, and the decode from the
// number of clocks given while LATCH was high.
// -----------------------------------------------------------------------------
module tb_led_panel_receiver;

    localparam int W  = 64;
    localparam int DW = 3 * W;

    logic          clk = 1'b0;
    logic          resetn;
    logic [2:0]    panel_rgb0;
    logic [2:0]    panel_rgb1;
    logic [4:0]    panel_addr;
    logic          panel_blank;
    logic          panel_latch;
    logic          panel_sclk;
    logic          row_valid;
    logic          row_ready;
    logic [4:0]    row_addr;
    logic [DW-1:0] row_data0;
    logic [DW-1:0] row_data1;
    logic [6:0]    row_cols;
    logic [15:0]   fm_reg1;
    logic [15:0]   fm_reg2;
    logic [1:0]    fm_written;
    logic          err_overrun;
    logic          err_cols;
    logic          err_latch;
    logic          clear_errors;

    always #5 clk = ~clk;

    led_panel_receiver #(
        .WIDTH       (W),
        .SYNC_STAGES (2)
    ) dut (
        .clk          (clk),
        .resetn       (resetn),
        .panel_rgb0   (panel_rgb0),
        .panel_rgb1   (panel_rgb1),
        .panel_addr   (panel_addr),
        .panel_blank  (panel_blank),
        .panel_latch  (panel_latch),
        .panel_sclk   (panel_sclk),
        .row_valid    (row_valid),
        .row_ready    (row_ready),
        .row_addr     (row_addr),
        .row_data0    (row_data0),
        .row_data1    (row_data1),
        .row_cols     (row_cols),
        .fm_reg1      (fm_reg1),
        .fm_reg2      (fm_reg2),
        .fm_written   (fm_written),
        .err_overrun  (err_overrun),
        .err_cols     (err_cols),
        .err_latch    (err_latch),
        .clear_errors (clear_errors)
    );

    int checks = 0;
    int passes = 0;

    // Reference model state
    logic [2:0]    hist0[$];
    logic [2:0]    hist1[$];
    int            m_cols;
    int            m_lat;
    logic [15:0]   m_sr;
    logic          m_valid;
    logic [4:0]    m_addr;
    logic [DW-1:0] m_data0;
    logic [DW-1:0] m_data1;
    int            m_row_cols;
    logic [15:0]   m_fm1;
    logic [15:0]   m_fm2;
    logic [1:0]    m_fmw;
    logic          m_ovr;
    logic          m_colerr;
    logic          m_laterr;
    logic          latch_lvl;
    logic [15:0]   fm_pattern;

    task automatic model_reset();
        hist0.delete();
        hist1.delete();
        m_cols = 0; m_lat = 0; m_sr = '0;
        m_valid = 1'b0; m_addr = '0; m_data0 = '0; m_data1 = '0; m_row_cols = 0;
        m_fm1 = '0; m_fm2 = '0; m_fmw = '0;
        m_ovr = 1'b0; m_colerr = 1'b0; m_laterr = 1'b0;
        latch_lvl = 1'b0;
    endtask

    // Row image = the most recent W columns, oldest at column 0
    function automatic logic [DW-1:0] model_window(input bit lower);
        logic [DW-1:0] r;
        int n;
        r = '0;
        n = hist0.size();
        for (int x = 0; x < W; x++) begin
            int idx;
            idx = n - W + x;
            if (idx >= 0) r[3*x +: 3] = lower ? hist1[idx] : hist0[idx];
        end
        return r;
    endfunction

    task automatic model_decode();
        if (m_lat == 0) begin
            if (m_cols != W) m_colerr = 1'b1;
            if (m_valid) begin
                m_ovr = 1'b1;
            end else begin
                m_valid    = 1'b1;
                m_addr     = panel_addr;
                m_data0    = model_window(1'b0);
                m_data1    = model_window(1'b1);
                m_row_cols = m_cols;
            end
        end else if (m_lat == 11) begin
            m_fm1 = m_sr; m_fmw[0] = 1'b1;
        end else if (m_lat == 12) begin
            m_fm2 = m_sr; m_fmw[1] = 1'b1;
        end else begin
            m_laterr = 1'b1;
        end
        m_cols = 0;
    endtask

    task automatic model_shift(input logic [2:0] a, input logic [2:0] b);
        hist0.push_back(a);
        hist1.push_back(b);
        m_sr = {m_sr[14:0], a[2]};
        if (m_cols < 127) m_cols++;
        if (latch_lvl && m_lat < 31) m_lat++;
    endtask

    // One column: data settles, SCLK high, SCLK low; each phase 2 clk cycles
    task automatic shift_col(input logic [2:0] a, input logic [2:0] b);
        panel_rgb0 = a;
        panel_rgb1 = b;
        repeat (2) @(negedge clk);
        panel_sclk = 1'b1;
        repeat (2) @(negedge clk);
        panel_sclk = 1'b0;
        repeat (2) @(negedge clk);
        model_shift(a, b);
    endtask

    task automatic raise_latch();
        panel_latch = 1'b1;
        latch_lvl   = 1'b1;
        m_lat       = 0;
        repeat (2) @(negedge clk);
    endtask

    // mode 0: random, 1: x mod 8 / ~x, 2: fm_pattern on red0 MSB first
    task automatic send_row(input int ncols, input int nlat, input int mode);
        for (int i = 0; i < ncols; i++) begin
            logic [2:0] a;
            logic [2:0] b;
            if (nlat > 0 && i == ncols - nlat) raise_latch();
            case (mode)
                1: begin a = 3'(i % 8); b = ~a; end
                2: begin
                    a = {fm_pattern[15 - (i % 16)], 2'($urandom_range(0, 3))};
                    b = 3'($urandom_range(0, 7));
                end
                default: begin
                    a = 3'($urandom_range(0, 7));
                    b = 3'($urandom_range(0, 7));
                end
            endcase
            shift_col(a, b);
        end
        if (nlat == 0) raise_latch();
        panel_latch = 1'b0;
        latch_lvl   = 1'b0;
        model_decode();
    endtask

    task automatic drain();
        row_ready = 1'b1;
        @(negedge clk);
        row_ready = 1'b0;
        m_valid   = 1'b0;
    endtask

    task automatic pulse_clear();
        clear_errors = 1'b1;
        @(negedge clk);
        clear_errors = 1'b0;
        m_ovr = 1'b0; m_colerr = 1'b0; m_laterr = 1'b0;
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        repeat (4) @(negedge clk);
        checks++; if (row_valid !== 1'b0) $display("[TB] FAIL reset_row_valid: got %0b want 0", row_valid); else passes++;
        checks++; if (row_data0 !== '0) $display("[TB] FAIL reset_row_data0: got %h want 0", row_data0); else passes++;
        checks++; if ({fm_reg1, fm_reg2, fm_written} !== '0) $display("[TB] FAIL reset_fm: got %h %h %b want 0", fm_reg1, fm_reg2, fm_written); else passes++;
        checks++; if ({err_overrun, err_cols, err_latch} !== 3'b000) $display("[TB] FAIL reset_errors: got %b want 000", {err_overrun, err_cols, err_latch}); else passes++;
        resetn = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
    endtask

    task automatic test_row_capture();
        panel_addr = 5'd5;
        send_row(W, 0, 1);
        // LATCH drop passes two sync flops, then is detected; the row appears one cycle later
        repeat (2) @(negedge clk);
        checks++; if (row_valid !== 1'b0) $display("[TB] FAIL row_valid_early: got %0b want 0", row_valid); else passes++;
        @(negedge clk);
        checks++; if (row_valid !== 1'b1) $display("[TB] FAIL row_valid_rise: got %0b want 1", row_valid); else passes++;
        checks++; if (row_addr !== 5'd5) $display("[TB] FAIL row_addr: got %0d want 5", row_addr); else passes++;
        checks++; if (row_cols !== 7'd64) $display("[TB] FAIL row_cols: got %0d want 64", row_cols); else passes++;
        checks++; if (row_data0[2:0] !== 3'd0) $display("[TB] FAIL row_col0: got %0d want 0", row_data0[2:0]); else passes++;
        checks++; if (row_data0[191:189] !== 3'd7) $display("[TB] FAIL row_col63: got %0d want 7", row_data0[191:189]); else passes++;
        checks++; if (row_data0 !== m_data0) $display("[TB] FAIL row_data0: got %h want %h", row_data0, m_data0); else passes++;
        checks++; if (row_data1 !== m_data1) $display("[TB] FAIL row_data1: got %h want %h", row_data1, m_data1); else passes++;
        checks++; if ({err_overrun, err_cols, err_latch} !== 3'b000) $display("[TB] FAIL row_no_errors: got %b want 000", {err_overrun, err_cols, err_latch}); else passes++;
        drain();
        checks++; if (row_valid !== 1'b0) $display("[TB] FAIL row_handshake_fall: got %0b want 0", row_valid); else passes++;
    endtask

    task automatic test_fm_regs();
        fm_pattern = 16'h7FFF;
        send_row(64, 11, 2);
        repeat (3) @(negedge clk);
        checks++; if (fm_reg1 !== m_fm1) $display("[TB] FAIL fm_reg1: got %h want %h", fm_reg1, m_fm1); else passes++;
        checks++; if (fm_written !== 2'b01) $display("[TB] FAIL fm_written_1: got %b want 01", fm_written); else passes++;
        checks++; if (row_valid !== 1'b0) $display("[TB] FAIL fm_no_row: got %0b want 0", row_valid); else passes++;
        fm_pattern = 16'h0040;
        send_row(32, 12, 2);
        repeat (3) @(negedge clk);
        checks++; if (fm_reg2 !== m_fm2) $display("[TB] FAIL fm_reg2: got %h want %h", fm_reg2, m_fm2); else passes++;
        checks++; if (fm_reg1 !== m_fm1) $display("[TB] FAIL fm_reg1_kept: got %h want %h", fm_reg1, m_fm1); else passes++;
        checks++; if (fm_written !== m_fmw) $display("[TB] FAIL fm_written_2: got %b want %b", fm_written, m_fmw); else passes++;
        checks++; if ({err_overrun, err_cols, err_latch} !== 3'b000) $display("[TB] FAIL fm_no_errors: got %b want 000", {err_overrun, err_cols, err_latch}); else passes++;
    endtask

    task automatic test_overrun();
        panel_addr = 5'($urandom_range(0, 31));
        send_row(W, 0, 0);
        repeat (3) @(negedge clk);
        panel_addr = 5'($urandom_range(0, 31));
        send_row(W, 0, 0);
        repeat (3) @(negedge clk);
        checks++; if (row_addr !== m_addr) $display("[TB] FAIL overrun_addr_held: got %0d want %0d", row_addr, m_addr); else passes++;
        checks++; if (row_data0 !== m_data0) $display("[TB] FAIL overrun_data_held: got %h want %h", row_data0, m_data0); else passes++;
        checks++; if (err_overrun !== m_ovr) $display("[TB] FAIL overrun_flag: got %0b want %0b", err_overrun, m_ovr); else passes++;
        pulse_clear();
        checks++; if (err_overrun !== 1'b0) $display("[TB] FAIL overrun_clear: got %0b want 0", err_overrun); else passes++;
        checks++; if (row_valid !== 1'b1) $display("[TB] FAIL overrun_still_valid: got %0b want 1", row_valid); else passes++;
        drain();
    endtask

    task automatic test_col_errors();
        panel_addr = 5'($urandom_range(0, 31));
        send_row(63, 0, 0);
        repeat (3) @(negedge clk);
        checks++; if (err_cols !== m_colerr) $display("[TB] FAIL cols_flag: got %0b want %0b", err_cols, m_colerr); else passes++;
        checks++; if (row_cols !== 7'(m_row_cols)) $display("[TB] FAIL cols_count: got %0d want %0d", row_cols, m_row_cols); else passes++;
        checks++; if (row_data0 !== m_data0) $display("[TB] FAIL cols_data0: got %h want %h", row_data0, m_data0); else passes++;
        drain();
        send_row(5, 5, 0);
        repeat (3) @(negedge clk);
        checks++; if (err_latch !== m_laterr) $display("[TB] FAIL latch_flag: got %0b want %0b", err_latch, m_laterr); else passes++;
        checks++; if ({fm_reg1, fm_reg2} !== {m_fm1, m_fm2}) $display("[TB] FAIL latch_fm_kept: got %h %h want %h %h", fm_reg1, fm_reg2, m_fm1, m_fm2); else passes++;
        checks++; if (row_valid !== 1'b0) $display("[TB] FAIL latch_no_row: got %0b want 0", row_valid); else passes++;
        pulse_clear();
        checks++; if ({err_cols, err_latch} !== 2'b00) $display("[TB] FAIL errors_clear: got %b want 00", {err_cols, err_latch}); else passes++;
    endtask

    task automatic test_random_rows();
        for (int r = 0; r < 4; r++) begin
            panel_addr = 5'($urandom_range(0, 31));
            send_row(W, 0, 0);
            repeat (3) @(negedge clk);
            checks++; if (row_addr !== m_addr) $display("[TB] FAIL rand_addr[%0d]: got %0d want %0d", r, row_addr, m_addr); else passes++;
            checks++; if (row_data0 !== m_data0) $display("[TB] FAIL rand_data0[%0d]: got %h want %h", r, row_data0, m_data0); else passes++;
            checks++; if (row_data1 !== m_data1) $display("[TB] FAIL rand_data1[%0d]: got %h want %h", r, row_data1, m_data1); else passes++;
            drain();
        end
    endtask

    task automatic test_coincident();
        logic [2:0] a;
        logic [2:0] b;
        panel_addr = 5'($urandom_range(0, 31));
        for (int i = 0; i < W; i++) shift_col(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        raise_latch();
        a = 3'($urandom_range(0, 7));
        b = 3'($urandom_range(0, 7));
        panel_rgb0 = a;
        panel_rgb1 = b;
        repeat (2) @(negedge clk);
        // SCLK rises in the same instant LATCH falls
        panel_sclk  = 1'b1;
        panel_latch = 1'b0;
        latch_lvl   = 1'b0;
        model_decode();
        model_shift(a, b);
        repeat (2) @(negedge clk);
        panel_sclk = 1'b0;
        repeat (2) @(negedge clk);
        checks++; if (row_cols !== 7'd64) $display("[TB] FAIL coinc_cols: got %0d want 64", row_cols); else passes++;
        checks++; if (row_data0 !== m_data0) $display("[TB] FAIL coinc_data0: got %h want %h", row_data0, m_data0); else passes++;
        drain();
        send_row(W - 1, 0, 0);
        repeat (3) @(negedge clk);
        checks++; if (row_cols !== 7'(m_row_cols)) $display("[TB] FAIL coinc_next_cols: got %0d want %0d", row_cols, m_row_cols); else passes++;
        checks++; if (err_cols !== m_colerr) $display("[TB] FAIL coinc_next_err: got %0b want %0b", err_cols, m_colerr); else passes++;
        checks++; if (row_data1 !== m_data1) $display("[TB] FAIL coinc_next_data1: got %h want %h", row_data1, m_data1); else passes++;
        drain();
    endtask

    task automatic test_reset_mid_row();
        panel_addr = 5'($urandom_range(1, 31));
        send_row(W, 0, 0);
        repeat (3) @(negedge clk);
        for (int i = 0; i < 30; i++) shift_col(3'($urandom_range(0, 7)), 3'($urandom_range(0, 7)));
        resetn = 1'b0;
        #1;
        checks++; if (row_valid !== 1'b0) $display("[TB] FAIL midreset_valid: got %0b want 0", row_valid); else passes++;
        checks++; if ({row_addr, row_cols} !== '0) $display("[TB] FAIL midreset_addr_cols: got %0d %0d want 0 0", row_addr, row_cols); else passes++;
        checks++; if ({row_data0, row_data1} !== '0) $display("[TB] FAIL midreset_data: got %h want 0", row_data0); else passes++;
        checks++; if ({fm_reg1, fm_reg2, fm_written} !== '0) $display("[TB] FAIL midreset_fm: got %h %h %b want 0", fm_reg1, fm_reg2, fm_written); else passes++;
        repeat (2) @(negedge clk);
        resetn = 1'b1;
        model_reset();
        repeat (2) @(negedge clk);
        send_row(W, 0, 0);
        repeat (3) @(negedge clk);
        checks++; if (row_valid !== 1'b1) $display("[TB] FAIL postreset_valid: got %0b want 1", row_valid); else passes++;
        checks++; if (row_cols !== 7'd64) $display("[TB] FAIL postreset_cols: got %0d want 64", row_cols); else passes++;
        checks++; if (row_data0 !== m_data0) $display("[TB] FAIL postreset_data0: got %h want %h", row_data0, m_data0); else passes++;
        checks++; if ({err_overrun, err_cols, err_latch} !== 3'b000) $display("[TB] FAIL postreset_errors: got %b want 000", {err_overrun, err_cols, err_latch}); else passes++;
        drain();
    endtask

    initial begin
        resetn       = 1'b0;
        panel_rgb0   = '0;
        panel_rgb1   = '0;
        panel_addr   = '0;
        panel_blank  = 1'b0;
        panel_latch  = 1'b0;
        panel_sclk   = 1'b0;
        row_ready    = 1'b0;
        clear_errors = 1'b0;
        fm_pattern   = '0;
        model_reset();
        @(negedge clk);
        test_reset();
        test_row_capture();
        test_fm_regs();
        test_overrun();
        test_col_errors();
        test_random_rows();
        test_coincident();
        test_reset_mid_row();
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
